// File: rtl/l1_resp_regbank.sv
// l1_resp_regbank: word-addressed register bank slave with a response queue.
// Every accepted request (read or write) yields one in-order response.
// The top register is a read-only count of accepted requests.
// Optional macro L1_RESP_REGBANK_ERR_EN: out-of-range addresses are ignored,
// reads return 0xBADCAB1E and a sticky err_o is raised. Without it, upper
// address bits alias onto the register index and err_o is tied low.
module l1_resp_regbank #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_DEV_WIDTH = 20,
  parameter int unsigned HOST_ADDR_W    = 1,
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                      clk_sys_in,
  input  logic                      rst_sys_in,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [HOST_ADDR_W-1:0]    req_ini_addr_i,
  input  logic [ADDR_DEV_WIDTH-1:0] req_tgt_addr_i,
  input  logic                      req_wen_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   req_be_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [HOST_ADDR_W-1:0]    resp_ini_addr_o,
  output logic [DATA_WIDTH-1:0]     resp_rdata_o,
  output logic                      err_o
);

  localparam int unsigned IdxW  = $clog2(NUM_REGS);
  localparam int unsigned BeW   = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] ErrData = DATA_WIDTH'(32'hBADCAB1E);
  localparam logic [IdxW-1:0] CntIdx = IdxW'(NUM_REGS - 1);

  // Register storage; index NUM_REGS-1 is the request counter, not stored here.
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
  logic [DATA_WIDTH-1:0] req_cnt_q;

  // Response queue.
  logic [DATA_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [HOST_ADDR_W-1:0] fifo_ini_q  [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ready_q, ready_d;

  logic                  accept;
  logic                  pop;
  logic [IdxW-1:0]       idx;
  logic                  upper_nz;
  logic                  out_of_range;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] resp_data;

  assign accept   = req_valid_i && ready_q;
  assign pop      = resp_valid_o && resp_ready_i;
  assign idx      = req_tgt_addr_i[IdxW+1:2];
  assign upper_nz = |(req_tgt_addr_i >> (IdxW + 2));

`ifdef L1_RESP_REGBANK_ERR_EN
  logic err_q;
  logic unused_addr;

  assign out_of_range = upper_nz;
  assign err_o        = err_q;
  assign unused_addr  = ^req_tgt_addr_i[1:0];

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      err_q <= 1'b0;
    end else if (accept && out_of_range) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_addr;

  // Upper address bits simply alias onto the index.
  assign out_of_range = 1'b0;
  assign err_o        = 1'b0;
  assign unused_addr  = ^{req_tgt_addr_i[1:0], upper_nz};
`endif

  assign wr_en = accept && req_wen_i && !out_of_range && (idx != CntIdx);

  // Read mux; the counter view already includes the request being accepted.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == IdxW'(i)) begin
        rd_word = regs_q[i];
      end
    end
    if (idx == CntIdx) begin
      rd_word = req_cnt_q + DATA_WIDTH'(1);
    end
  end

  // Response payload captured at acceptance: 0 for writes.
  always_comb begin
    resp_data = '0;
    if (!req_wen_i) begin
      resp_data = out_of_range ? ErrData : rd_word;
    end
  end

  // Byte-enabled register writes.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (idx == IdxW'(i)) begin
          for (int b = 0; b < BeW; b++) begin
            if (req_be_i[b]) begin
              regs_q[i][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Accepted-request counter, wraps naturally.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      req_cnt_q <= '0;
    end else if (accept) begin
      req_cnt_q <= req_cnt_q + DATA_WIDTH'(1);
    end
  end

  // Queue pointer/occupancy next state; ready is a registered view of occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CntW'(FIFO_DEPTH));
  end

  // Queue control state.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Queue storage; a push never lands on the head entry while it is valid.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_ini_q[i]  <= '0;
      end
    end else if (accept) begin
      fifo_data_q[wr_ptr_q] <= resp_data;
      fifo_ini_q[wr_ptr_q]  <= req_ini_addr_i;
    end
  end

  assign req_ready_o     = ready_q;
  assign resp_valid_o    = (count_q != '0);
  assign resp_rdata_o    = fifo_data_q[rd_ptr_q];
  assign resp_ini_addr_o = fifo_ini_q[rd_ptr_q];

endmodule

// File: doc/l1_resp_regbank.md
L1_RESP_REGBANK -- requirements
Module: l1_resp_regbank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-002 SHALL have parameter ADDR_DEV_WIDTH, default 20, device-side byte address width.
REQ-003 SHALL have parameter HOST_ADDR_W, default 1, initiator address width.
REQ-004 SHALL have parameter NUM_REGS, default 16, number of word registers, power of two, min 4.
REQ-005 SHALL have parameter FIFO_DEPTH, default 2, response queue depth, min 1.
REQ-006 SHALL have port clk_sys_in, input, 1, system clock; rising edge active.
REQ-007 SHALL have port rst_sys_in, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port req_valid_i, input, 1, request valid from interconnect.
REQ-009 SHALL have port req_ready_o, output, 1, block can accept a request.
REQ-010 SHALL have port req_ini_addr_i, input, HOST_ADDR_W, initiator of the request.
REQ-011 SHALL have port req_tgt_addr_i, input, ADDR_DEV_WIDTH, byte address; bits [1:0] ignored.
REQ-012 SHALL have port req_wen_i, input, 1, 1 = write, 0 = read.
REQ-013 SHALL have port req_wdata_i, input, DATA_WIDTH, write data.
REQ-014 SHALL have port req_be_i, input, DATA_WIDTH/8, byte enables.
REQ-015 SHALL have port resp_valid_o, output, 1, response valid.
REQ-016 SHALL have port resp_ready_i, input, 1, interconnect accepts the response.
REQ-017 SHALL have port resp_ini_addr_o, output, HOST_ADDR_W, initiator echoed with the response.
REQ-018 SHALL have port resp_rdata_o, output, DATA_WIDTH, read data; 0 for write responses.
REQ-019 SHALL have port err_o, output, 1, sticky out-of-range flag.

Function
REQ-020 SHALL accept a request in any cycle where req_valid_i && req_ready_o.
REQ-021 SHALL drive req_ready_o = (queue count < FIFO_DEPTH), registered; no combinational path from resp_ready_i.
REQ-022 SHALL produce exactly one response per accepted request, reads and writes alike, in acceptance order.
REQ-023 SHALL present a response no earlier than the cycle after acceptance; with an empty queue, resp_valid_o rises exactly one cycle after acceptance.
REQ-024 SHALL hold resp_valid_o, resp_rdata_o and resp_ini_addr_o stable until resp_valid_o && resp_ready_i, then pop.
REQ-025 SHALL, on a same-cycle push and pop with the queue full, refuse the push (ready already low) and perform only the pop.
REQ-026 SHALL decode the word index as req_tgt_addr_i[log2(NUM_REGS)+1:2].
REQ-027 SHALL, on a write, update only the bytes whose req_be_i bit is 1; be = 0 leaves the register unchanged but still responds.
REQ-028 SHALL treat register NUM_REGS-1 as a read-only counter of accepted requests, wrapping 0xFFFFFFFF -> 0; writes to it are ignored.
REQ-029 SHALL sample read data at acceptance, so a read accepted the cycle after a write to the same index returns the new value.
REQ-030 SHALL sample the counter value at acceptance, including the current request.

Reset
REQ-031 SHALL, on rst_sys_in low, asynchronously clear all registers, the counter, the queue and err_o, and drive resp_valid_o = 0 and req_ready_o = 0.
REQ-032 SHALL raise req_ready_o on the first clock edge after reset release.
REQ-033 SHALL discard any queued or in-flight responses on reset mid-operation.

Configuration
REQ-034 SHALL use macro L1_RESP_REGBANK_ERR_EN to control out-of-range handling.
REQ-035 SHALL, with L1_RESP_REGBANK_ERR_EN defined, treat any address bit above [log2(NUM_REGS)+1] being nonzero as out of range: the access is ignored, the read response is 0xBADCAB1E, and err_o is set until reset.
REQ-036 SHALL, without L1_RESP_REGBANK_ERR_EN, alias upper address bits onto the register index, and tie err_o to 0.

Verification
REQ-037 Reset, then write 0xA5A5A5A5 be=4'hF to 0x08, then read 0x08 -> write response rdata 0, read rdata 0xA5A5A5A5, resp_valid_o exactly 1 cycle after each acceptance.
REQ-038 Write 0x11223344 be=4'b0101 to 0x04 holding 0 -> read returns 0x00220044.
REQ-039 Hold resp_ready_i=0 and issue 3 reads with ini_addr alternating 0/1 -> req_ready_o falls after 2 acceptances; release ready -> 3 responses in order, ini_addr 0,1,0.
REQ-040 After reset issue 5 requests, the fifth a read of 0x3C -> rdata 5; a write to 0x3C leaves the counter at its incremented value.
REQ-041 With L1_RESP_REGBANK_ERR_EN defined, read 0x40 -> rdata 0xBADCAB1E, err_o=1 held; without the macro -> returns register 0 contents, err_o=0.
REQ-042 Assert reset with 2 queued responses -> resp_valid_o=0 immediately; after release no stale response appears.
